countdown_manager: RTL and testbench

- Countdown counterpart of the stopwatch time manager: loads a preset MM:SS, counts down once per second while enabled, and raises an alarm on reaching 00:00.
- Sits between the front-panel inputs (preset switches, start/stop) and the same 7-segment display path the stopwatch drives.
- Minutes/seconds output format matches the stopwatch (6-bit binary each, 0..59).

---
 rtl/countdown_manager.sv | 135 +++++++++++++
 tb/tb_countdown_manager.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_manager.sv
// Countdown timer: loads a clamped MM:SS preset, decrements once per prescaled
// tick while running, and holds an alarm for ALARM_TICKS ticks after expiry.
module countdown_manager #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  input  logic       start_stop,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       alarm,
  output logic       expired
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ACNT_LAST  = AW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_ALARM
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    min_d, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          running_d, alarm_d, expired_d;

  logic          counting, tick, value_zero, dec_zero, alarm_last;
  logic [5:0]    dec_min, dec_sec, clamp_min, clamp_sec;

  assign counting   = (state_q == ST_RUN) || (state_q == ST_ALARM);
  assign tick       = counting && (presc_q == PRESC_LAST);
  assign value_zero = (minutes == 6'd0) && (seconds == 6'd0);
  assign alarm_last = (acnt_q == ACNT_LAST);
  assign clamp_min  = (set_minutes > 6'd59) ? 6'd59 : set_minutes;
  assign clamp_sec  = (set_seconds > 6'd59) ? 6'd59 : set_seconds;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch can be inferred.
  always_comb begin
    dec_min = minutes;
    dec_sec = seconds;
    if (seconds != 6'd0) begin
      dec_sec = seconds - 6'd1;
    end else if (minutes != 6'd0) begin
      dec_min = minutes - 6'd1;
      dec_sec = 6'd59;
    end
  end

  assign dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0);

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load overrides everything; expiry wins over a simultaneous pause request.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start_stop && !value_zero) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && dec_zero)   state_d = ST_ALARM;
          else if (!start_stop)   state_d = ST_PAUSE;
        end
        ST_PAUSE: if (start_stop) state_d = ST_RUN;
        ST_ALARM: if (tick && alarm_last) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    min_d     = minutes;
    sec_d     = seconds;
    presc_d   = presc_q;
    acnt_d    = acnt_q;
    if (load) begin
      min_d   = clamp_min;
      sec_d   = clamp_sec;
      presc_d = '0;
      acnt_d  = '0;
    end else begin
      if (counting) presc_d = tick ? '0 : presc_q + 1'b1;
      if (state_q == ST_RUN && tick) begin
        min_d = dec_min;
        sec_d = dec_sec;
      end
      if (state_q == ST_ALARM && tick) acnt_d = alarm_last ? '0 : acnt_q + 1'b1;
    end
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
    expired_d = !load && (state_q == ST_RUN) && tick && dec_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minutes <= '0;
      seconds <= '0;
      presc_q <= '0;
      acnt_q  <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
      expired <= 1'b0;
    end else begin
      minutes <= min_d;
      seconds <= sec_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      running <= running_d;
      alarm   <= alarm_d;
      expired <= expired_d;
    end
  end

endmodule

// File: tb/tb_countdown_manager.sv
// Directed bench for countdown_manager with TICK_DIV=4, ALARM_TICKS=2.
module tb_countdown_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       start_stop;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       alarm;
  logic       expired;

  int total = 0;
  int bad   = 0;

  countdown_manager #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .set_minutes (set_minutes),
    .set_seconds (set_seconds),
    .start_stop  (start_stop),
    .minutes     (minutes),
    .seconds     (seconds),
    .running     (running),
    .alarm       (alarm),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] s);
    set_minutes = m;
    set_seconds = s;
    load        = 1'b1;
    cyc();
    load        = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; set_minutes = '0; set_seconds = '0; start_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_min", minutes, 0);
    check("rst_sec", seconds, 0);
    check("rst_run", running, 0);
    check("rst_alarm", alarm, 0);
    check("rst_exp", expired, 0);
    rst = 1'b0;
    cyc();

    // 00:03 countdown to expiry and alarm window
    do_load(6'd0, 6'd3);
    check("t1_load_sec", seconds, 3);
    check("t1_load_run", running, 0);
    start_stop = 1'b1;
    cyc();
    check("t1_enter_run", running, 1);
    repeat (3) cyc();
    check("t1_sec3_hold", seconds, 3);
    cyc();
    check("t1_sec2", seconds, 2);
    repeat (4) cyc();
    check("t1_sec1", seconds, 1);
    repeat (3) cyc();
    check("t1_no_exp_early", expired, 0);
    cyc();
    check("t1_sec0", seconds, 0);
    check("t1_exp_pulse", expired, 1);
    check("t1_alarm_on", alarm, 1);
    check("t1_run_off", running, 0);
    cyc();
    check("t1_exp_single", expired, 0);
    repeat (6) cyc();
    check("t1_alarm_c8", alarm, 1);
    cyc();
    check("t1_alarm_off", alarm, 0);
    check("t1_idle_run", running, 0);
    cyc();
    check("t1_no_restart", running, 0);
    check("t1_final_min", minutes, 0);

    // 01:00 borrows into 00:59; loading 00:00 never starts
    do_load(6'd1, 6'd0);
    check("t2_load_min", minutes, 1);
    check("t2_load_idle", running, 0);
    cyc();
    repeat (4) cyc();
    check("t2_borrow_min", minutes, 0);
    check("t2_borrow_sec", seconds, 59);
    do_load(6'd0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t2_zero_run", running, 0);
      check("t2_zero_exp", expired, 0);
    end
    check("t2_zero_sec", seconds, 0);

    // clamping of out-of-range presets
    start_stop = 1'b0;
    do_load(6'd63, 6'd60);
    check("t3_clamp_min", minutes, 59);
    check("t3_clamp_sec", seconds, 59);
    check("t3_clamp_idle", running, 0);

    // pause with prescaler at 2, resume finishes the interrupted second
    do_load(6'd0, 6'd5);
    start_stop = 1'b1;
    cyc();
    cyc();
    start_stop = 1'b0;
    cyc();
    check("t4_paused_run", running, 0);
    repeat (10) cyc();
    check("t4_frozen_sec", seconds, 5);
    check("t4_frozen_run", running, 0);
    start_stop = 1'b1;
    cyc();
    check("t4_resume_run", running, 1);
    check("t4_resume_sec", seconds, 5);
    cyc();
    check("t4_pre_tick", seconds, 5);
    cyc();
    check("t4_post_tick", seconds, 4);

    // load during RUN returns to IDLE and clears the prescaler
    cyc();
    do_load(6'd0, 6'd10);
    check("t5_load_idle", running, 0);
    check("t5_load_sec", seconds, 10);
    cyc();
    check("t5_rerun", running, 1);
    repeat (3) cyc();
    check("t5_presc_clr", seconds, 10);
    cyc();
    check("t5_first_dec", seconds, 9);

    // load during ALARM drops the alarm on the next edge
    do_load(6'd0, 6'd1);
    cyc();
    repeat (4) cyc();
    check("t5_alarm_set", alarm, 1);
    check("t5_alarm_exp", expired, 1);
    cyc();
    start_stop = 1'b0;
    do_load(6'd0, 6'd2);
    check("t5_alarm_drop", alarm, 0);
    check("t5_alarm_sec", seconds, 2);
    check("t5_alarm_run", running, 0);

    // asynchronous reset mid-RUN clears outputs without waiting for an edge
    do_load(6'd0, 6'd1);
    start_stop = 1'b1;
    cyc();
    check("t6_running", running, 1);
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_sec", seconds, 0);
    check("t6_async_run", running, 0);
    check("t6_async_alarm", alarm, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_no_exp", expired, 0);
      check("t6_no_alarm", alarm, 0);
    end
    rst = 1'b0;
    cyc();
    check("t6_post_idle", running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
